fifo_axis_reader: RTL and testbench

Read-side companion to the team's synchronous show-ahead FIFO. It drains words from the FIFO read port (rd_en/dout/empty) and emits them as an AXI-Stream-style master: valid/ready/data/last. Each packet is started by a length command. A 2-entry output skid buffer keeps every output registered and removes any combinational path from tready to fifo_rd_en. It sits between packet/crypto datapath FIFOs and downstream stream consumers.

---
 rtl/fifo_rd_pkg.sv | 13 +
 rtl/axis_skid_buf.sv | 69 ++++++
 rtl/fifo_axis_reader.sv | 90 +++++++++
 tb/tb_fifo_axis_reader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rd_pkg.sv
// Shared types and default widths for the FIFO-to-AXI-Stream read path.
package fifo_rd_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int LEN_W_DEF  = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STREAM = 2'd1,
    ST_DRAIN  = 2'd2
  } rd_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered stream buffer; entry 0 drives the m_axis outputs directly.
module axis_skid_buf #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] data1;
  logic              last1;
  logic              pop;

  assign pop           = (occ != 2'd0) && m_axis_tready;
  assign m_axis_tvalid = (occ != 2'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ          <= 2'd0;
      m_axis_tdata <= '0;
      m_axis_tlast <= 1'b0;
      data1        <= '0;
      last1        <= 1'b0;
    end else begin
      case ({in_valid, pop})
        2'b10: begin
          if (occ == 2'd0) begin
            m_axis_tdata <= in_data;
            m_axis_tlast <= in_last;
          end else begin
            data1 <= in_data;
            last1 <= in_last;
          end
          occ <= occ + 2'd1;
        end
        2'b01: begin
          // Draining to empty clears tlast so a stale flag never lingers on the head.
          if (occ == 2'd2) begin
            m_axis_tdata <= data1;
            m_axis_tlast <= last1;
          end else begin
            m_axis_tlast <= 1'b0;
          end
          occ <= occ - 2'd1;
        end
        2'b11: begin
          if (occ == 2'd2) begin
            m_axis_tdata <= data1;
            m_axis_tlast <= last1;
            data1        <= in_data;
            last1        <= in_last;
          end else begin
            m_axis_tdata <= in_data;
            m_axis_tlast <= in_last;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_axis_reader.sv
// Drains a show-ahead FIFO into an AXI-Stream master, one packet per length command.
module fifo_axis_reader
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              fifo_rd_en,
  input  logic [DATA_W-1:0] fifo_dout,
  input  logic              fifo_empty,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tlast,
  output logic              busy,
  output logic              done
);

  // state     | meaning
  // ST_IDLE   | waiting for a length command
  // ST_STREAM | issuing FIFO reads until the last beat has been read
  // ST_DRAIN  | reads finished, waiting for the tlast handshake

  rd_state_e        state_q;
  logic [LEN_W-1:0] remaining_q;
  logic [1:0]       occ;
  logic             last_rd;
  logic             pop;

  assign cmd_ready  = (state_q == ST_IDLE);
  assign busy       = (state_q != ST_IDLE);
  // Read enable depends on registered state and FIFO flags only, never on tready.
  assign fifo_rd_en = (state_q == ST_STREAM) && !fifo_empty && (occ != 2'd2);
  assign last_rd    = (remaining_q == LEN_W'(1));
  assign pop        = m_axis_tvalid && m_axis_tready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid) begin
            if (cmd_len != '0) begin
              remaining_q <= cmd_len;
              state_q     <= ST_STREAM;
            end else begin
              done <= 1'b1;
            end
          end
        end
        ST_STREAM: begin
          if (fifo_rd_en) begin
            remaining_q <= remaining_q - LEN_W'(1);
            if (last_rd) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (pop && m_axis_tlast) begin
            state_q <= ST_IDLE;
            done    <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  axis_skid_buf #(.DATA_W(DATA_W)) u_skid (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (fifo_rd_en),
    .in_data       (fifo_dout),
    .in_last       (last_rd),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .occ           (occ)
  );

endmodule

// File: tb/tb_fifo_axis_reader.sv
// Scoreboard bench for fifo_axis_reader with a behavioural show-ahead FIFO model.
module tb_fifo_axis_reader;

  localparam int DATA_W = 32;
  localparam int LEN_W  = 16;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic              fifo_rd_en;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_empty;
  logic              m_axis_tvalid;
  logic              m_axis_tready = 1'b1;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tlast;
  logic              busy;
  logic              done;

  fifo_axis_reader #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_len       (cmd_len),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_dout     (fifo_dout),
    .fifo_empty    (fifo_empty),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  // FIFO model
  logic [DATA_W-1:0] mem [0:63];
  logic [5:0]        wr_ptr = '0;
  logic [5:0]        rd_ptr = '0;
  logic              force_empty = 1'b0;
  assign fifo_dout  = mem[rd_ptr];
  assign fifo_empty = force_empty || (wr_ptr == rd_ptr);

  logic [DATA_W:0]   exp_q [$];
  int                cmd_log [$];
  int                rd_log [$];
  int                done_log [$];
  logic              done_busy [$];
  logic [DATA_W-1:0] beat_data [$];
  logic              beat_last [$];
  int                beat_cyc [$];
  int                rd_viol = 0;
  int                stall_viol = 0;
  logic              hold_v = 1'b0;
  logic [DATA_W-1:0] hold_d = '0;
  logic              hold_l = 1'b0;
  logic              rd_s;
  int                cyc = 0;
  int                total = 0;
  int                passed = 0;

  always @(posedge clk) cyc++;

  always begin
    @(negedge clk);
    rd_s = fifo_rd_en;
    if (cmd_valid && cmd_ready) cmd_log.push_back(cyc);
    if (fifo_rd_en) begin
      rd_log.push_back(cyc);
      if (fifo_empty) rd_viol++;
    end
    if (m_axis_tvalid && m_axis_tready) begin
      beat_data.push_back(m_axis_tdata);
      beat_last.push_back(m_axis_tlast);
      beat_cyc.push_back(cyc);
    end
    if (hold_v && (!m_axis_tvalid || m_axis_tdata !== hold_d || m_axis_tlast !== hold_l))
      stall_viol++;
    hold_v = m_axis_tvalid && !m_axis_tready;
    hold_d = m_axis_tdata;
    hold_l = m_axis_tlast;
    if (done) begin
      done_log.push_back(cyc);
      done_busy.push_back(busy);
    end
    @(posedge clk);
    #1;
    if (rd_s && rst_n) rd_ptr = rd_ptr + 6'd1;
  end

  task automatic push_word(input logic [DATA_W-1:0] d, input logic last);
    mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 6'd1;
    exp_q.push_back({last, d});
  endtask

  task automatic clear_logs();
    exp_q.delete(); cmd_log.delete(); rd_log.delete(); done_log.delete();
    done_busy.delete(); beat_data.delete(); beat_last.delete(); beat_cyc.delete();
    rd_viol = 0; stall_viol = 0; hold_v = 1'b0;
  endtask

  task automatic send_cmd(input int len);
    int n0;
    n0 = cmd_log.size();
    cmd_valid = 1'b1;
    cmd_len = len[LEN_W-1:0];
    for (int i = 0; i < 100 && cmd_log.size() == n0; i++) begin
      @(posedge clk); #2;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int n);
    for (int i = 0; i < 300 && done_log.size() < n; i++) begin
      @(posedge clk); #2;
    end
    total++;
    if (done_log.size() != n) $display("FAIL done_count: got %0d want %0d", done_log.size(), n);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    total++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, done, busy, fifo_rd_en, cmd_ready} !==
        {1'b0, 1'b0, {DATA_W{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset_outputs: tvalid=%b tlast=%b tdata=%h done=%b busy=%b rd_en=%b cmd_ready=%b",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, done, busy, fifo_rd_en, cmd_ready);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) $display("FAIL post_reset: cmd_ready=%b busy=%b want 1/0", cmd_ready, busy);
    else passed++;
  endtask

  task automatic test_basic();
    logic [DATA_W:0] e;
    clear_logs();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 4; i++) push_word(32'hA000_0000 + DATA_W'(i), i == 3);
    send_cmd(4);
    wait_done(1);
    repeat (2) begin @(posedge clk); #2; end
    total++;
    if (rd_log.size() != 4 || rd_log[0] != cmd_log[0] + 1 || rd_log[3] - rd_log[0] != 3)
      $display("FAIL basic_rd_en: got %0d reads, first at +%0d want 4 consecutive at +1", rd_log.size(),
               rd_log.size() > 0 ? rd_log[0] - cmd_log[0] : -1);
    else passed++;
    total++;
    if (beat_data.size() != 4) $display("FAIL basic_beats: got %0d want 4", beat_data.size());
    else passed++;
    total++;
    if (beat_cyc.size() != 4 || rd_log.size() == 0 || beat_cyc[0] != rd_log[0] + 1 || beat_cyc[3] - beat_cyc[0] != 3)
      $display("FAIL basic_beat_timing: beats=%0d want 4 consecutive one cycle after first rd_en", beat_cyc.size());
    else passed++;
    for (int i = 0; i < beat_data.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      total++;
      if ({beat_last[i], beat_data[i]} !== e)
        $display("FAIL basic_beat%0d: got last=%b data=%h want last=%b data=%h", i, beat_last[i], beat_data[i], e[DATA_W], e[DATA_W-1:0]);
      else passed++;
    end
    total++;
    if (done_log.size() != 1 || beat_cyc.size() != 4 || done_log[0] != beat_cyc[3] + 1 || done_busy[0] !== 1'b0)
      $display("FAIL basic_done: done pulses=%0d want one, 1 cycle after tlast, busy low", done_log.size());
    else passed++;
  endtask

  task automatic test_backpressure();
    logic [DATA_W:0] e;
    clear_logs();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'hB100_0000 + DATA_W'(i), i == 7);
    send_cmd(8);
    for (int i = 0; i < 50 && beat_data.size() < 2; i++) begin @(posedge clk); #2; end
    m_axis_tready = 1'b0;
    repeat (5) begin @(posedge clk); #2; end
    total++;
    if (rd_log.size() != 4 || dut.occ !== 2'd2)
      $display("FAIL stall_rd_stop: reads=%0d occ=%0d want 4 and 2", rd_log.size(), dut.occ);
    else passed++;
    m_axis_tready = 1'b1;
    wait_done(1);
    total++;
    if (stall_viol != 0 || beat_data.size() != 8)
      $display("FAIL stall_hold: unstable=%0d beats=%0d want 0 and 8", stall_viol, beat_data.size());
    else passed++;
    for (int i = 0; i < beat_data.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      total++;
      if ({beat_last[i], beat_data[i]} !== e)
        $display("FAIL stall_beat%0d: got last=%b data=%h want last=%b data=%h", i, beat_last[i], beat_data[i], e[DATA_W], e[DATA_W-1:0]);
      else passed++;
    end
  endtask

  task automatic test_fifo_empty();
    logic [DATA_W:0] e;
    clear_logs();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 6; i++) push_word(32'hC200_0000 + DATA_W'(i), i == 5);
    force_empty = 1'b1;
    send_cmd(6);
    for (int k = 0; k < 200 && done_log.size() < 1; k++) begin
      force_empty = ((k / 2) % 2) == 1;
      @(posedge clk); #2;
    end
    force_empty = 1'b0;
    total++;
    if (rd_viol != 0 || done_log.size() != 1)
      $display("FAIL empty_rd: reads while empty=%0d done=%0d want 0 and 1", rd_viol, done_log.size());
    else passed++;
    total++;
    if (beat_cyc.size() != 6 || beat_cyc[5] - beat_cyc[0] <= 5)
      $display("FAIL empty_bubbles: beats=%0d want 6 with gaps", beat_cyc.size());
    else passed++;
    for (int i = 0; i < beat_data.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      total++;
      if ({beat_last[i], beat_data[i]} !== e)
        $display("FAIL empty_beat%0d: got last=%b data=%h want last=%b data=%h", i, beat_last[i], beat_data[i], e[DATA_W], e[DATA_W-1:0]);
      else passed++;
    end
  endtask

  task automatic test_zero_len();
    int rdy_bad;
    clear_logs();
    rdy_bad = 0;
    send_cmd(0);
    repeat (4) begin
      if (cmd_ready !== 1'b1) rdy_bad++;
      @(posedge clk); #2;
    end
    total++;
    if (done_log.size() != 1 || cmd_log.size() != 1 || done_log[0] != cmd_log[0] + 1)
      $display("FAIL zero_done: pulses=%0d want one pulse the cycle after the command", done_log.size());
    else passed++;
    total++;
    if (rd_log.size() != 0 || beat_data.size() != 0 || rdy_bad != 0)
      $display("FAIL zero_quiet: reads=%0d beats=%0d cmd_ready_low=%0d want 0/0/0", rd_log.size(), beat_data.size(), rdy_bad);
    else passed++;
  endtask

  task automatic test_reset_mid();
    clear_logs();
    m_axis_tready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'hD300_0000 + DATA_W'(i), i == 7);
    send_cmd(8);
    for (int i = 0; i < 50 && rd_log.size() < 3; i++) begin @(posedge clk); #2; end
    rst_n = 1'b0;
    #1;
    total++;
    if ({m_axis_tvalid, m_axis_tlast, m_axis_tdata, done, busy, fifo_rd_en} !== {1'b0, 1'b0, {DATA_W{1'b0}}, 1'b0, 1'b0, 1'b0})
      $display("FAIL async_reset: tvalid=%b tlast=%b tdata=%h done=%b busy=%b rd_en=%b want all 0",
               m_axis_tvalid, m_axis_tlast, m_axis_tdata, done, busy, fifo_rd_en);
    else passed++;
    total++;
    if (6'(wr_ptr - rd_ptr) != 6'd5 || fifo_dout !== 32'hD300_0003)
      $display("FAIL reset_fifo_left: words=%0d head=%h want 5 and d3000003", 6'(wr_ptr - rd_ptr), fifo_dout);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #2;
    total++;
    if (cmd_ready !== 1'b1 || dut.occ !== 2'd0)
      $display("FAIL reset_release: cmd_ready=%b occ=%0d want 1 and 0", cmd_ready, dut.occ);
    else passed++;
    rd_ptr = wr_ptr;
  endtask

  task automatic test_back_to_back();
    logic [DATA_W:0] e;
    clear_logs();
    m_axis_tready = 1'b1;
    push_word(32'hB000_0000, 1'b1);
    push_word(32'hC000_0000, 1'b0);
    push_word(32'hC000_0001, 1'b1);
    send_cmd(1);
    send_cmd(2);
    wait_done(2);
    total++;
    if (cmd_log.size() != 2 || done_log.size() != 2 || cmd_log[1] != done_log[0])
      $display("FAIL b2b_cmd_ready: cmds=%0d second at %0d want at first done %0d", cmd_log.size(),
               cmd_log.size() > 1 ? cmd_log[1] : -1, done_log.size() > 0 ? done_log[0] : -1);
    else passed++;
    total++;
    if (beat_data.size() != 3) $display("FAIL b2b_beats: got %0d want 3", beat_data.size());
    else passed++;
    for (int i = 0; i < beat_data.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      total++;
      if ({beat_last[i], beat_data[i]} !== e)
        $display("FAIL b2b_beat%0d: got last=%b data=%h want last=%b data=%h", i, beat_last[i], beat_data[i], e[DATA_W], e[DATA_W-1:0]);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_fifo_empty();
    test_zero_len();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
